// File: rtl/argmax_unit.sv
// argmax_unit
//
// Arg-max / arg-min finder for the classifier output stage. A vector of
// NUM_INPUT scores is captured over a valid/ready handshake, scanned LANES
// elements per cycle, and the winning index/value is presented on a
// backpressured output until the consumer takes it. Ties keep the lower index.
//
// Ports:
//   i_clk        clock, rising edge
//   reset        synchronous, active-high
//   i_data       NUM_INPUT packed elements, element k at [k*INPUT_WIDTH +: INPUT_WIDTH]
//   i_find_min   0 = arg-max, 1 = arg-min (sampled with i_data)
//   i_valid      input vector valid
//   o_ready      block can accept a vector
//   o_index      winning element index, zero-extended to IDX_W
//   o_value      winning element value
//   o_valid      result valid
//   i_ready      consumer accepts the result
module argmax_unit #(
  parameter int NUM_INPUT   = 10,
  parameter int INPUT_WIDTH = 16,
  parameter int LANES       = 1,
  parameter int SIGNED      = 1,
  parameter int IDX_W       = 32
) (
  input  logic                             i_clk,
  input  logic                             reset,
  input  logic [NUM_INPUT*INPUT_WIDTH-1:0] i_data,
  input  logic                             i_find_min,
  input  logic                             i_valid,
  output logic                             o_ready,
  output logic [IDX_W-1:0]                 o_index,
  output logic [INPUT_WIDTH-1:0]           o_value,
  output logic                             o_valid,
  input  logic                             i_ready
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]             state;
  logic [INPUT_WIDTH-1:0] elem_buf [NUM_INPUT];
  logic                   find_min_r;
  logic [INPUT_WIDTH-1:0] best_val;
  logic [IDX_W-1:0]       best_idx;
  logic [IDX_W-1:0]       ptr;

  logic [INPUT_WIDTH-1:0] nxt_val;
  logic [IDX_W-1:0]       nxt_idx;
  logic [INPUT_WIDTH-1:0] cand_val;
  int                     cand_pos;
  logic                   last_scan;

  // Strict comparison only, so an equal candidate never displaces the
  // incumbent. Both operands are widened by one bit so a single signed
  // compare covers the signed and unsigned interpretations.
  function automatic logic beats(input logic [INPUT_WIDTH-1:0] cand,
                                 input logic [INPUT_WIDTH-1:0] best,
                                 input logic                   find_min);
    logic signed [INPUT_WIDTH:0] c_s;
    logic signed [INPUT_WIDTH:0] b_s;
    c_s = {((SIGNED != 0) & cand[INPUT_WIDTH-1]), cand};
    b_s = {((SIGNED != 0) & best[INPUT_WIDTH-1]), best};
    if (find_min) return c_s < b_s;
    else          return c_s > b_s;
  endfunction

  // Lane reduce: lanes are folded in ascending index order onto the running
  // best, so with strict comparison the lowest index wins every tie, both
  // within this group and against earlier cycles.
  always_comb begin
    nxt_val  = best_val;
    nxt_idx  = best_idx;
    cand_pos = 0;
    cand_val = '0;
    for (int j = 0; j < LANES; j++) begin
      cand_pos = int'(ptr) + j;
      cand_val = '0;
      for (int k = 0; k < NUM_INPUT; k++) begin
        if (k == cand_pos) cand_val = elem_buf[k];
      end
      if ((cand_pos < NUM_INPUT) && beats(cand_val, nxt_val, find_min_r)) begin
        nxt_val = cand_val;
        nxt_idx = IDX_W'(cand_pos);
      end
    end
    last_scan = (int'(ptr) + LANES >= NUM_INPUT);
  end

  // Capture / scan / hold
  always_ff @(posedge i_clk) begin
    if (reset) begin
      state      <= IDLE;
      find_min_r <= 1'b0;
      best_val   <= '0;
      best_idx   <= '0;
      ptr        <= IDX_W'(1);
      o_index    <= '0;
      o_value    <= '0;
      for (int k = 0; k < NUM_INPUT; k++) elem_buf[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            for (int k = 0; k < NUM_INPUT; k++)
              elem_buf[k] <= i_data[k*INPUT_WIDTH +: INPUT_WIDTH];
            find_min_r <= i_find_min;
            best_val   <= i_data[INPUT_WIDTH-1:0];
            best_idx   <= '0;
            ptr        <= IDX_W'(1);
            if (NUM_INPUT == 1) begin
              // Single element: it is the answer, no scan needed.
              o_index <= '0;
              o_value <= i_data[INPUT_WIDTH-1:0];
              state   <= DONE;
            end else begin
              state   <= SCAN;
            end
          end
        end
        SCAN: begin
          best_val <= nxt_val;
          best_idx <= nxt_idx;
          ptr      <= ptr + IDX_W'(LANES);
          if (last_scan) begin
            o_index <= nxt_idx;
            o_value <= nxt_val;
            state   <= DONE;
          end
        end
        DONE: begin
          if (i_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake outputs decode registered state only; reset gates them so no
  // result or acceptance is advertised while the block is being cleared.
  assign o_ready = (state == IDLE) & ~reset;
  assign o_valid = (state == DONE) & ~reset;

endmodule

// File: tb/tb_argmax_unit.sv
module tb_argmax_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int lat;
  logic stable_ok;

  // u0: defaults (N=10, L=1, signed)
  logic [159:0] d0;  logic fm0, v0, r0, ordy0, ovld0;
  logic [31:0] oidx0; logic [15:0] oval0;
  // u1: L=4
  logic [159:0] d1;  logic fm1, v1, r1, ordy1, ovld1;
  logic [31:0] oidx1; logic [15:0] oval1;
  // u2: unsigned
  logic [159:0] d2;  logic fm2, v2, r2, ordy2, ovld2;
  logic [31:0] oidx2; logic [15:0] oval2;
  // u3: N=1
  logic [15:0] d3;   logic fm3, v3, r3, ordy3, ovld3;
  logic [31:0] oidx3; logic [15:0] oval3;
  // u4: L=N=10
  logic [159:0] d4;  logic fm4, v4, r4, ordy4, ovld4;
  logic [31:0] oidx4; logic [15:0] oval4;

  argmax_unit u0 (.i_clk(clk), .reset(reset), .i_data(d0), .i_find_min(fm0), .i_valid(v0),
                  .o_ready(ordy0), .o_index(oidx0), .o_value(oval0), .o_valid(ovld0), .i_ready(r0));
  argmax_unit #(.LANES(4)) u1 (.i_clk(clk), .reset(reset), .i_data(d1), .i_find_min(fm1), .i_valid(v1),
                  .o_ready(ordy1), .o_index(oidx1), .o_value(oval1), .o_valid(ovld1), .i_ready(r1));
  argmax_unit #(.SIGNED(0)) u2 (.i_clk(clk), .reset(reset), .i_data(d2), .i_find_min(fm2), .i_valid(v2),
                  .o_ready(ordy2), .o_index(oidx2), .o_value(oval2), .o_valid(ovld2), .i_ready(r2));
  argmax_unit #(.NUM_INPUT(1)) u3 (.i_clk(clk), .reset(reset), .i_data(d3), .i_find_min(fm3), .i_valid(v3),
                  .o_ready(ordy3), .o_index(oidx3), .o_value(oval3), .o_valid(ovld3), .i_ready(r3));
  argmax_unit #(.LANES(10)) u4 (.i_clk(clk), .reset(reset), .i_data(d4), .i_find_min(fm4), .i_valid(v4),
                  .o_ready(ordy4), .o_index(oidx4), .o_value(oval4), .o_valid(ovld4), .i_ready(r4));

  // Elements 3,7,2,9,1,9,0,4,5,8 (element 0 in the low bits)
  localparam logic [159:0] VEC_A = {16'd8, 16'd5, 16'd4, 16'd0, 16'd9, 16'd1, 16'd9, 16'd2, 16'd7, 16'd3};
  // Elements 5,-3,0,-3,12,-8,-8,1,2,7
  localparam logic [159:0] VEC_B = {16'd7, 16'd2, 16'd1, 16'hFFF8, 16'hFFF8, 16'd12, 16'hFFFD, 16'd0, 16'hFFFD, 16'd5};
  // 0x7FFF at index 2, 0x8000 at index 6, zeros elsewhere
  localparam logic [159:0] VEC_C = {48'd0, 16'h8000, 48'd0, 16'h7FFF, 32'd0};

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++; if (ordy0 !== 1'b0) begin fails++; $display("FAIL reset_ready_low got=%b exp=0", ordy0); end
    tests++; if (ovld0 !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", ovld0); end
    tests++; if (oidx0 !== 32'd0 || oval0 !== 16'd0) begin fails++; $display("FAIL reset_outputs idx=%0d val=%h exp 0/0", oidx0, oval0); end
    reset = 1'b0;
    #1;
    tests++; if (ordy0 !== 1'b1) begin fails++; $display("FAIL reset_ready_after got=%b exp=1", ordy0); end
  endtask

  task automatic test_max_default();
    @(negedge clk);
    d0 = VEC_A; fm0 = 1'b0; r0 = 1'b1; v0 = 1'b1;
    @(posedge clk); #1 v0 = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!ovld0 && lat < 50);
    tests++; if (lat !== 10) begin fails++; $display("FAIL max_latency got=%0d exp=10", lat); end
    tests++; if (oidx0 !== 32'd3) begin fails++; $display("FAIL max_index got=%0d exp=3", oidx0); end
    tests++; if (oval0 !== 16'd9) begin fails++; $display("FAIL max_value got=%h exp=0009", oval0); end
    @(negedge clk);
    tests++; if (ovld0 !== 1'b0) begin fails++; $display("FAIL max_valid_one_cycle got=%b exp=0", ovld0); end
    tests++; if (oidx0 !== 32'd3) begin fails++; $display("FAIL max_index_held got=%0d exp=3", oidx0); end
    tests++; if (ordy0 !== 1'b1) begin fails++; $display("FAIL max_ready_back got=%b exp=1", ordy0); end
  endtask

  task automatic test_signed_min_lanes();
    @(negedge clk);
    d1 = VEC_B; fm1 = 1'b1; r1 = 1'b1; v1 = 1'b1;
    @(posedge clk); #1 v1 = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!ovld1 && lat < 50);
    tests++; if (lat !== 4) begin fails++; $display("FAIL smin_latency got=%0d exp=4", lat); end
    tests++; if (oidx1 !== 32'd5) begin fails++; $display("FAIL smin_index got=%0d exp=5", oidx1); end
    tests++; if (oval1 !== 16'hFFF8) begin fails++; $display("FAIL smin_value got=%h exp=fff8", oval1); end
  endtask

  task automatic test_signedness();
    @(negedge clk);
    d2 = VEC_C; fm2 = 1'b0; r2 = 1'b1; v2 = 1'b1;
    d0 = VEC_C; fm0 = 1'b0; r0 = 1'b1; v0 = 1'b1;
    @(posedge clk); #1 begin v2 = 1'b0; v0 = 1'b0; end
    lat = 0;
    do begin @(negedge clk); lat++; end while (!(ovld2 && ovld0) && lat < 50);
    tests++; if (oidx2 !== 32'd6) begin fails++; $display("FAIL unsigned_index got=%0d exp=6", oidx2); end
    tests++; if (oval2 !== 16'h8000) begin fails++; $display("FAIL unsigned_value got=%h exp=8000", oval2); end
    tests++; if (oidx0 !== 32'd2) begin fails++; $display("FAIL signed_index got=%0d exp=2", oidx0); end
    tests++; if (oval0 !== 16'h7FFF) begin fails++; $display("FAIL signed_value got=%h exp=7fff", oval0); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    d0 = VEC_A; fm0 = 1'b0; r0 = 1'b0; v0 = 1'b1;
    @(posedge clk); #1 v0 = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!ovld0 && lat < 50);
    tests++; if (lat !== 10) begin fails++; $display("FAIL bp_latency got=%0d exp=10", lat); end
    // second vector offered while the result is stalled
    d0 = VEC_A; fm0 = 1'b1; v0 = 1'b1;
    stable_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ovld0 !== 1'b1 || oidx0 !== 32'd3 || oval0 !== 16'd9 || ordy0 !== 1'b0) stable_ok = 1'b0;
    end
    tests++; if (stable_ok !== 1'b1) begin fails++; $display("FAIL bp_hold got=%b exp=1 (idx=%0d val=%h vld=%b rdy=%b)", stable_ok, oidx0, oval0, ovld0, ordy0); end
    r0 = 1'b1;
    @(negedge clk);
    tests++; if (ordy0 !== 1'b1) begin fails++; $display("FAIL bp_ready_after_release got=%b exp=1", ordy0); end
    tests++; if (ovld0 !== 1'b0) begin fails++; $display("FAIL bp_valid_drop got=%b exp=0", ovld0); end
    @(posedge clk); #1 v0 = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!ovld0 && lat < 50);
    tests++; if (lat !== 10) begin fails++; $display("FAIL bp_second_latency got=%0d exp=10", lat); end
    tests++; if (oidx0 !== 32'd6 || oval0 !== 16'd0) begin fails++; $display("FAIL bp_second_result idx=%0d val=%h exp 6/0000", oidx0, oval0); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_scan();
    @(negedge clk);
    d0 = VEC_B; fm0 = 1'b0; r0 = 1'b1; v0 = 1'b1;
    @(posedge clk); #1 v0 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests++; if (ovld0 !== 1'b0) begin fails++; $display("FAIL rst_mid_valid got=%b exp=0", ovld0); end
    tests++; if (oidx0 !== 32'd0 || oval0 !== 16'd0) begin fails++; $display("FAIL rst_mid_outputs idx=%0d val=%h exp 0/0000", oidx0, oval0); end
    tests++; if (ordy0 !== 1'b1) begin fails++; $display("FAIL rst_mid_ready got=%b exp=1", ordy0); end
    // aborted vector must never produce a result
    lat = 0;
    stable_ok = 1'b1;
    repeat (12) begin @(negedge clk); if (ovld0 !== 1'b0) stable_ok = 1'b0; end
    tests++; if (stable_ok !== 1'b1) begin fails++; $display("FAIL rst_mid_no_result got=%b exp=1", stable_ok); end
    d0 = VEC_B; fm0 = 1'b0; v0 = 1'b1;
    @(posedge clk); #1 v0 = 1'b0;
    do begin @(negedge clk); lat++; end while (!ovld0 && lat < 50);
    tests++; if (oidx0 !== 32'd4 || oval0 !== 16'd12 || lat !== 10) begin fails++; $display("FAIL rst_mid_recover idx=%0d val=%h lat=%0d exp 4/000c/10", oidx0, oval0, lat); end
    @(negedge clk);
  endtask

  task automatic test_edge_params();
    @(negedge clk);
    d3 = 16'hABCD; fm3 = 1'b0; r3 = 1'b1; v3 = 1'b1;
    d4 = {10{16'h0042}}; fm4 = 1'b0; r4 = 1'b1; v4 = 1'b1;
    @(posedge clk); #1 begin v3 = 1'b0; v4 = 1'b0; end
    @(negedge clk);
    tests++; if (ovld3 !== 1'b1) begin fails++; $display("FAIL n1_latency valid=%b exp=1 at T+1", ovld3); end
    tests++; if (oidx3 !== 32'd0 || oval3 !== 16'hABCD) begin fails++; $display("FAIL n1_result idx=%0d val=%h exp 0/abcd", oidx3, oval3); end
    tests++; if (ovld4 !== 1'b0) begin fails++; $display("FAIL wide_early valid=%b exp=0 at T+1", ovld4); end
    @(negedge clk);
    tests++; if (ovld4 !== 1'b1) begin fails++; $display("FAIL wide_latency valid=%b exp=1 at T+2", ovld4); end
    tests++; if (oidx4 !== 32'd0 || oval4 !== 16'h0042) begin fails++; $display("FAIL wide_tie idx=%0d val=%h exp 0/0042", oidx4, oval4); end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    d0 = '0; fm0 = 0; v0 = 0; r0 = 0;
    d1 = '0; fm1 = 0; v1 = 0; r1 = 0;
    d2 = '0; fm2 = 0; v2 = 0; r2 = 0;
    d3 = '0; fm3 = 0; v3 = 0; r3 = 0;
    d4 = '0; fm4 = 0; v4 = 0; r4 = 0;
    test_reset();
    test_max_default();
    test_signed_min_lanes();
    test_signedness();
    test_backpressure();
    test_reset_mid_scan();
    test_edge_params();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
